// File: rtl/instruction_cache_dm.sv
// Direct-mapped instruction cache. Each set holds one instruction, a tag and a
// valid bit. A miss issues a refill request to the backing memory and waits
// for its acknowledge. Hit and miss counters saturate at all-ones.
module instruction_cache_dm #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_SETS      = 16,   // power of two, at least 2
    parameter int OFFSET_BITS   = 3,
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     fetch_req_i,
    input  logic [ADDR_WIDTH-1:0]    pc_i,
    input  logic                     flush_i,
    output logic                     fetch_ready_o,
    output logic                     instr_valid_o,
    output logic [DATA_WIDTH-1:0]    instruction_o,
    output logic                     mem_req_o,
    output logic [ADDR_WIDTH-1:0]    mem_addr_o,
    input  logic                     mem_ack_i,
    input  logic [DATA_WIDTH-1:0]    mem_data_i,
    output logic [COUNTER_WIDTH-1:0] hit_count_o,
    output logic [COUNTER_WIDTH-1:0] miss_count_o
);

    localparam int SET_BITS = $clog2(NUM_SETS);
    localparam int BLOCK_W  = ADDR_WIDTH - OFFSET_BITS;
    localparam int TAG_W    = BLOCK_W - SET_BITS;
    localparam logic [ADDR_WIDTH-1:0]    OFFSET_MASK = ADDR_WIDTH'((64'd1 << OFFSET_BITS) - 64'd1);
    localparam logic [COUNTER_WIDTH-1:0] COUNT_ONE   = COUNTER_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, REFILL, RESPOND} state_t;

    state_t state_q, state_d;

    logic [TAG_W-1:0]      tag_mem  [NUM_SETS];
    logic [DATA_WIDTH-1:0] data_mem [NUM_SETS];
    logic [NUM_SETS-1:0]   valid_q;

    logic [SET_BITS-1:0]      req_set_q;
    logic [TAG_W-1:0]         req_tag_q;
    logic [DATA_WIDTH-1:0]    refill_data_q;
    logic                     instr_valid_q;
    logic [DATA_WIDTH-1:0]    instruction_q;
    logic                     mem_req_q;
    logic [ADDR_WIDTH-1:0]    mem_addr_q;
    logic [COUNTER_WIDTH-1:0] hit_count_q;
    logic [COUNTER_WIDTH-1:0] miss_count_q;

    // Address decomposition of the incoming PC.
    logic [BLOCK_W-1:0]    pc_block;
    logic [SET_BITS-1:0]   pc_set;
    logic [TAG_W-1:0]      pc_tag;
    logic [ADDR_WIDTH-1:0] pc_line_addr;
    logic                  accept;
    logic                  lookup_hit;
    logic                  refill_done;

    assign pc_block     = pc_i[ADDR_WIDTH-1:OFFSET_BITS];
    assign pc_set       = pc_block[SET_BITS-1:0];
    assign pc_tag       = pc_block[BLOCK_W-1:SET_BITS];
    assign pc_line_addr = pc_i & ~OFFSET_MASK;
    assign accept       = fetch_req_i && (state_q == IDLE);
    // Lookup reads the registered valid bits, so a flush in the same cycle
    // does not hide a hit on the request being accepted.
    assign lookup_hit   = valid_q[pc_set] && (tag_mem[pc_set] == pc_tag);
    assign refill_done  = (state_q == REFILL) && mem_ack_i;

    // State register.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic: misses refill and then respond; hits stay in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !lookup_hit) state_d = REFILL;
            REFILL:  if (mem_ack_i)             state_d = RESPOND;
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: the cache only accepts requests while idle.
    always_comb begin
        fetch_ready_o = (state_q == IDLE);
    end

    // Tag/data arrays: written only when a refill completes.
    always_ff @(posedge clock_i) begin
        if (refill_done) begin
            tag_mem[req_set_q]  <= req_tag_q;
            data_mem[req_set_q] <= mem_data_i;
        end
    end

    // Valid bits: flush takes priority over a completing refill.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i)          valid_q <= '0;
        else if (flush_i)     valid_q <= '0;
        else if (refill_done) valid_q[req_set_q] <= 1'b1;
    end

    // Registered outputs, refill bookkeeping and saturating counters.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            instr_valid_q <= 1'b0;
            instruction_q <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            req_set_q     <= '0;
            req_tag_q     <= '0;
            refill_data_q <= '0;
            hit_count_q   <= '0;
            miss_count_q  <= '0;
        end else begin
            instr_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept && lookup_hit) begin
                        instr_valid_q <= 1'b1;
                        instruction_q <= data_mem[pc_set];
                        if (hit_count_q != '1) hit_count_q <= hit_count_q + COUNT_ONE;
                    end else if (accept) begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= pc_line_addr;
                        req_set_q  <= pc_set;
                        req_tag_q  <= pc_tag;
                        if (miss_count_q != '1) miss_count_q <= miss_count_q + COUNT_ONE;
                    end
                end
                REFILL: begin
                    if (mem_ack_i) begin
                        mem_req_q     <= 1'b0;
                        refill_data_q <= mem_data_i;
                    end
                end
                RESPOND: begin
                    instr_valid_q <= 1'b1;
                    instruction_q <= refill_data_q;
                end
                default: ;
            endcase
        end
    end

    assign instr_valid_o = instr_valid_q;
    assign instruction_o = instruction_q;
    assign mem_req_o     = mem_req_q;
    assign mem_addr_o    = mem_addr_q;
    assign hit_count_o   = hit_count_q;
    assign miss_count_o  = miss_count_q;

endmodule
